// File: rtl/tdc_pkg.sv
// Shared constants, width helpers and encodings for the TDC back-end.
package tdc_pkg;

    // Default geometry of the TDC core
    localparam int CNT_W_DEF   = 7;
    localparam int NPH_DEF     = 16;
    localparam int AVG_MAX_DEF = 3;

    // avg_sel carries log2 of the averaging depth
    localparam int AVG_SEL_W = 2;
    localparam logic [AVG_SEL_W-1:0] AVG_1 = 2'd0;
    localparam logic [AVG_SEL_W-1:0] AVG_2 = 2'd1;
    localparam logic [AVG_SEL_W-1:0] AVG_4 = 2'd2;
    localparam logic [AVG_SEL_W-1:0] AVG_8 = 2'd3;

    // Averaging control: waiting for a reference sample, then producing words
    typedef enum logic {
        ST_UNPRIMED = 1'b0,
        ST_PRIMED   = 1'b1
    } tdc_state_t;

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Fine index covers both polarities of the cyclic thermometer: 2*NPH codes
    function automatic int ph_w(input int nph);
        return clog2(2 * nph);
    endfunction

    function automatic int out_w(input int cnt_w, input int nph);
        return cnt_w + ph_w(nph);
    endfunction

endpackage

// File: rtl/tdc_therm_decode.sv
// Cyclic thermometer edge decoder: returns the highest transition position
// and flags words that contain more than one transition.
module tdc_therm_decode
    import tdc_pkg::*;
#(
    parameter int NPH = NPH_DEF,
    localparam int PH_W = ph_w(NPH)
) (
    input  logic [NPH-1:0]  phase,
    output logic [PH_W-1:0] idx,
    output logic            bubble
);

    logic [NPH-1:1] fall;
    logic [NPH-1:1] rise;
    logic [PH_W-1:0] n_edges;

    genvar gi;
    generate
        for (gi = 1; gi < NPH; gi++) begin : g_edge
            assign fall[gi] = phase[gi-1] & ~phase[gi];
            assign rise[gi] = ~phase[gi-1] & phase[gi];
        end
    endgenerate

    // Priority scan: later (higher) taps overwrite earlier hits
    always_comb begin
        idx     = phase[0] ? PH_W'(NPH - 1) : PH_W'(2 * NPH - 1);
        n_edges = '0;
        for (int j = 1; j < NPH; j++) begin
            if (fall[j]) begin
                idx     = PH_W'(j - 1);
                n_edges = n_edges + 1'b1;
            end else if (rise[j]) begin
                idx     = PH_W'(j - 1 + NPH);
                n_edges = n_edges + 1'b1;
            end
        end
        bubble = (n_edges > PH_W'(1));
    end

endmodule

// File: rtl/tdc_digital_avg.sv
// TDC digital back-end: sample, decode fine edge, form modulo phase
// difference against the previous sample, optionally average 2^n words.
module tdc_digital_avg
    import tdc_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int NPH     = NPH_DEF,
    parameter int AVG_MAX = AVG_MAX_DEF,
    localparam int PH_W   = ph_w(NPH),
    localparam int OUT_W  = CNT_W + PH_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [CNT_W-1:0]     counter_in,
    input  logic [NPH-1:0]       phase_in,
    input  logic [AVG_SEL_W-1:0] avg_sel,
    output logic [OUT_W-1:0]     tdc_word,
    output logic                 tdc_valid,
    output logic                 bubble_err
);

    localparam int ACC_W = OUT_W + AVG_MAX;
    localparam int N_W   = (AVG_MAX > 0) ? clog2(AVG_MAX + 1) : 1;
    localparam int BLK_W = (AVG_MAX > 0) ? AVG_MAX : 1;

    // Stage 0 capture
    logic [CNT_W-1:0] s0_counter_reg;
    logic [NPH-1:0]   s0_phase_reg;
    logic             s0_vld_reg;

    // Stage 1 / averaging state
    tdc_state_t       state_reg, state_next;
    logic [CNT_W-1:0] counter_last_reg, counter_last_next;
    logic [PH_W-1:0]  idx_last_reg, idx_last_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [BLK_W-1:0] blk_cnt_reg, blk_cnt_next;
    logic [N_W-1:0]   n_blk_reg, n_blk_next;
    logic             bflag_reg, bflag_next;
    logic [OUT_W-1:0] tdc_word_reg, tdc_word_next;
    logic             tdc_valid_reg, tdc_valid_next;
    logic             bubble_err_reg, bubble_err_next;

    // Combinational datapath
    logic [PH_W-1:0]  idx;
    logic             bubble;
    logic [CNT_W-1:0] aux;
    logic [CNT_W-1:0] coarse_diff;
    logic [OUT_W-1:0] word;
    logic [N_W-1:0]   n_sel;
    logic [N_W-1:0]   n_cur;
    logic [ACC_W-1:0] acc_sum;
    logic             blk_last;

    tdc_therm_decode #(
        .NPH (NPH)
    ) u_decode (
        .phase  (s0_phase_reg),
        .idx    (idx),
        .bubble (bubble)
    );

    // Capture raw inputs on enabled edges; data holds across en gaps
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_counter_reg <= '0;
            s0_phase_reg   <= '0;
            s0_vld_reg     <= 1'b0;
        end else begin
            s0_vld_reg <= en;
            if (en) begin
                s0_counter_reg <= counter_in;
                s0_phase_reg   <= phase_in;
            end
        end
    end

    // Phase difference arithmetic, all modulo the natural widths
    always_comb begin
        aux         = s0_counter_reg - CNT_W'(s0_phase_reg[0]);
        coarse_diff = counter_last_reg - aux;
        word        = {coarse_diff, PH_W'(0)} + OUT_W'(idx) - OUT_W'(idx_last_reg);
        n_sel       = (int'(avg_sel) > AVG_MAX) ? N_W'(AVG_MAX) : N_W'(avg_sel);
        n_cur       = (blk_cnt_reg == '0) ? n_sel : n_blk_reg;
        acc_sum     = acc_reg + ACC_W'(word);
        blk_last    = ((int'(blk_cnt_reg) + 1) == (1 << n_cur));
    end

    // Priming / averaging control and next-state of all stage-1 registers
    always_comb begin
        state_next        = state_reg;
        counter_last_next = counter_last_reg;
        idx_last_next     = idx_last_reg;
        acc_next          = acc_reg;
        blk_cnt_next      = blk_cnt_reg;
        n_blk_next        = n_blk_reg;
        bflag_next        = bflag_reg;
        tdc_word_next     = tdc_word_reg;
        tdc_valid_next    = 1'b0;
        bubble_err_next   = bubble_err_reg;
        if (s0_vld_reg) begin
            counter_last_next = aux;
            idx_last_next     = idx;
            case (state_reg)
                ST_UNPRIMED: begin
                    state_next = ST_PRIMED;
                end
                ST_PRIMED: begin
                    n_blk_next = n_cur;
                    if (blk_last) begin
                        tdc_word_next   = OUT_W'(acc_sum >> n_cur);
                        bubble_err_next = bflag_reg | bubble;
                        tdc_valid_next  = 1'b1;
                        acc_next        = '0;
                        blk_cnt_next    = '0;
                        bflag_next      = 1'b0;
                    end else begin
                        acc_next     = acc_sum;
                        blk_cnt_next = blk_cnt_reg + 1'b1;
                        bflag_next   = bflag_reg | bubble;
                    end
                end
                default: state_next = ST_UNPRIMED;
            endcase
        end
    end

    // Stage-1 state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_UNPRIMED;
            counter_last_reg <= '0;
            idx_last_reg     <= '0;
            acc_reg          <= '0;
            blk_cnt_reg      <= '0;
            n_blk_reg        <= '0;
            bflag_reg        <= 1'b0;
            tdc_word_reg     <= '0;
            tdc_valid_reg    <= 1'b0;
            bubble_err_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            counter_last_reg <= counter_last_next;
            idx_last_reg     <= idx_last_next;
            acc_reg          <= acc_next;
            blk_cnt_reg      <= blk_cnt_next;
            n_blk_reg        <= n_blk_next;
            bflag_reg        <= bflag_next;
            tdc_word_reg     <= tdc_word_next;
            tdc_valid_reg    <= tdc_valid_next;
            bubble_err_reg   <= bubble_err_next;
        end
    end

    assign tdc_word   = tdc_word_reg;
    assign tdc_valid  = tdc_valid_reg;
    assign bubble_err = bubble_err_reg;

endmodule

// File: tb/tb_tdc_digital_avg.sv
// Scoreboard bench for tdc_digital_avg: directed cases plus random traffic.
module tb_tdc_digital_avg;

    localparam int CNT_W = 7;
    localparam int NPH   = 16;
    localparam int PH_W  = 5;
    localparam int OUT_W = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [CNT_W-1:0] counter_in = '0;
    logic [NPH-1:0]   phase_in = '0;
    logic [1:0]       avg_sel = 2'd0;
    logic [OUT_W-1:0] tdc_word;
    logic             tdc_valid;
    logic             bubble_err;

    int checks = 0;
    int failures = 0;
    int outputs_seen = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int word;
        bit bub;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state
    bit   pend_vld = 1'b0;
    int   pend_cnt;
    logic [NPH-1:0] pend_ph;
    bit   primed = 1'b0;
    int   last_aux = 0;
    int   last_idx = 0;
    int   blk_len = 1;
    int   blk_fill = 0;
    int   blk_sum = 0;
    bit   blk_bub = 1'b0;
    int   hold_word = 0;
    bit   hold_bub = 1'b0;

    tdc_digital_avg #(
        .CNT_W   (CNT_W),
        .NPH     (NPH),
        .AVG_MAX (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .counter_in (counter_in),
        .phase_in   (phase_in),
        .avg_sel    (avg_sel),
        .tdc_word   (tdc_word),
        .tdc_valid  (tdc_valid),
        .bubble_err (bubble_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Highest-transition decode with bubble count, straight from the rules
    function automatic void decode(input logic [NPH-1:0] p, output int idx, output bit bub);
        int n;
        n = 0;
        idx = p[0] ? NPH - 1 : 2 * NPH - 1;
        for (int j = 1; j < NPH; j++) begin
            if (p[j-1] != p[j]) begin
                n++;
                idx = p[j-1] ? j - 1 : j - 1 + NPH;
            end
        end
        bub = (n > 1);
    endfunction

    // One captured sample reaching the difference stage
    task automatic model_sample(input int c, input logic [NPH-1:0] p, input int sel);
        int idx, aux, word;
        bit bub;
        decode(p, idx, bub);
        aux = (c - int'(p[0])) & ((1 << CNT_W) - 1);
        if (!primed) begin
            primed = 1'b1;
        end else begin
            word = ((((last_aux - aux) & ((1 << CNT_W) - 1)) << PH_W) + idx - last_idx)
                   & ((1 << OUT_W) - 1);
            if (blk_fill == 0) blk_len = 1 << ((sel > 3) ? 3 : sel);
            blk_sum += word;
            blk_bub |= bub;
            blk_fill++;
            if (blk_fill == blk_len) begin
                exp_q.push_back('{word: (blk_sum / blk_len) & ((1 << OUT_W) - 1), bub: blk_bub});
                blk_fill = 0;
                blk_sum = 0;
                blk_bub = 1'b0;
            end
        end
        last_aux = aux;
        last_idx = idx;
    endtask

    // Model advances on every clock edge: a sample captured at one edge is
    // differenced at the next, with the avg_sel present there
    always @(posedge clk) begin
        if (rst) begin
            pend_vld = 1'b0;
            primed = 1'b0;
            last_aux = 0;
            last_idx = 0;
            blk_fill = 0;
            blk_sum = 0;
            blk_bub = 1'b0;
            hold_word = 0;
            hold_bub = 1'b0;
            exp_q.delete();
        end else begin
            if (pend_vld) model_sample(pend_cnt, pend_ph, int'(avg_sel));
            pend_vld = en;
            if (en) begin
                pend_cnt = int'(counter_in);
                pend_ph = phase_in;
            end
        end
    end

    // Monitor: pop on every valid, otherwise the outputs must hold
    always @(negedge clk) begin
        if (mon_en) begin
            if (tdc_valid) begin
                outputs_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid actual=word %0d expected=no output", tdc_word);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_word", int'(tdc_word), e.word);
                    chk("sb_bubble", int'(bubble_err), int'(e.bub));
                    hold_word = e.word;
                    hold_bub = e.bub;
                end
            end else begin
                chk("hold_word", int'(tdc_word), hold_word);
                chk("hold_bubble", int'(bubble_err), int'(hold_bub));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int c, input int p);
        counter_in = CNT_W'(c);
        phase_in = NPH'(p);
        en = 1'b1;
        step();
        en = 1'b0;
    endtask

    function automatic logic [NPH-1:0] gen_phase();
        int k;
        logic [NPH-1:0] ones;
        k = $urandom_range(0, NPH - 1);
        ones = NPH'((32'd1 << (k + 1)) - 1);
        case ($urandom_range(0, 3))
            0: return ones;
            1: return ~ones;
            default: return NPH'($urandom);
        endcase
    endfunction

    initial begin
        step();
        step();
        chk("reset_word", int'(tdc_word), 0);
        chk("reset_valid", int'(tdc_valid), 0);
        chk("reset_bubble", int'(bubble_err), 0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Basic difference and two-edge latency
        send(10, 'h00FF);
        step();
        chk("t1_first_no_valid", int'(tdc_valid), 0);
        send(6, 'h00FF);
        step();
        chk("t1_valid", int'(tdc_valid), 1);
        chk("t1_word", int'(tdc_word), 128);
        chk("t1_bubble", int'(bubble_err), 0);

        // No-transition words
        send(20, 'hFFFF);
        send(20, 'h0000);
        step();
        chk("t2_word", int'(tdc_word), 4080);

        // Bubble
        send(10, 'h00FF);
        send(6, 'h00F3);
        step();
        chk("t3_word", int'(tdc_word), 128);
        chk("t3_bubble", int'(bubble_err), 1);

        // Counter wrap
        send(1, 'h00FF);
        send(127, 'h00FE);
        step();
        chk("t5_word", int'(tdc_word), 32);

        // Averaging over 4 with a mid-block avg_sel change
        send(10, 'h00FF);
        step();
        avg_sel = 2'd2;
        send(6, 'h00FF);
        send(2, 'h03FF);
        avg_sel = 2'd0;
        send(126, 'h00FF);
        chk("t4_no_valid_mid", int'(tdc_valid), 0);
        send(122, 'h0FFF);
        step();
        chk("t4_avg_valid", int'(tdc_valid), 1);
        chk("t4_avg_word", int'(tdc_word), 129);
        send(122, 'h0FFF);
        step();
        chk("t4_direct_after", int'(tdc_word), 0);

        // en gap
        send(10, 'h00FF);
        repeat (5) step();
        send(6, 'h00FF);
        step();
        chk("t6_gap_word", int'(tdc_word), 128);

        // Reset mid-block
        avg_sel = 2'd2;
        send(10, 'h00FF);
        send(6, 'h00FF);
        send(2, 'h00FF);
        rst = 1'b1;
        avg_sel = 2'd0;
        step();
        rst = 1'b0;
        chk("t6_rst_word", int'(tdc_word), 0);
        chk("t6_rst_valid", int'(tdc_valid), 0);
        send(50, 'h00FF);
        step();
        chk("t6_first_fresh_valid", int'(tdc_valid), 0);
        chk("t6_first_fresh_word", int'(tdc_word), 0);
        send(46, 'h00FF);
        step();
        chk("t6_second_fresh_valid", int'(tdc_valid), 1);
        chk("t6_second_fresh_word", int'(tdc_word), 128);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(0, 3) != 0);
            counter_in = CNT_W'($urandom);
            phase_in = gen_phase();
            if ($urandom_range(0, 24) == 0) avg_sel = 2'($urandom);
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0;
        en = 1'b0;
        repeat (4) step();

        chk("queue_drained", exp_q.size(), 0);
        checks++;
        if (outputs_seen < 100) begin
            failures++;
            $display("FAIL output_count actual=%0d required=at least 100", outputs_seen);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
